// File: rtl/shift_register_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_pkg
// Purpose  : Default geometry constants and the data-word type shared by the
//            row-matrix shift register and its users.
// Contents : DATA_BITS   - width of one data word
//            MATRIX_SIZE - number of independent rows / head outputs
//            OUTPUT_SIZE - depth of each row in words (2*MATRIX_SIZE-1)
//            word_t      - one data word at the default width
// Revision : 1.0 - initial release
// ============================================================================
package shift_register_pkg;

  localparam int DATA_BITS   = 8;
  localparam int MATRIX_SIZE = 8;
  localparam int OUTPUT_SIZE = 2 * MATRIX_SIZE - 1;

  typedef logic [DATA_BITS-1:0] word_t;

endpackage : shift_register_pkg
`default_nettype wire

// File: rtl/shift_register_row.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_row
// Purpose  : One row of the matrix shift register: a DEPTH-word storage line
//            with parallel load, one-word-per-edge shift towards word 0, and
//            the head word (word 0) presented combinationally.
// Ports    : clock   - rising-edge clock
//            reset   - synchronous active-high clear of every word
//            load    - capture data_in into the row (beats shift)
//            shift   - advance the row by one word
//            data_in - parallel load image, word j lands in position j
//            head    - current word 0 of the row
// Config   : SHIFT_REGISTER_ROTATE_EN - when defined, a shift feeds word 0
//            back into the tail (circular rotate); otherwise the tail is
//            zero-filled.
// Revision : 1.0 - initial release
// ============================================================================
module shift_register_row
  import shift_register_pkg::*;
#(
  parameter int DATA_BITS = shift_register_pkg::DATA_BITS,
  parameter int DEPTH     = shift_register_pkg::OUTPUT_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] data_in [0:DEPTH-1],
  output logic [DATA_BITS-1:0] head
);

  logic [DATA_BITS-1:0] r_mem [0:DEPTH-1];

  // Priority per edge: reset, then load, then shift, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= '0;
      end
    end else if (load) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= data_in[j];
      end
    end else if (shift) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        r_mem[j] <= r_mem[j+1];
      end
`ifdef SHIFT_REGISTER_ROTATE_EN
      // Old head wraps round to the tail so the row never drains.
      r_mem[DEPTH-1] <= r_mem[0];
`else
      // Tail is refilled with zeros, so a long shift run drains the row.
      r_mem[DEPTH-1] <= '0;
`endif
    end
  end

  // Head is taken straight from storage: it reflects an update in the same
  // cycle the storage changes, with no extra output register.
  assign head = r_mem[0];

endmodule : shift_register_row
`default_nettype wire

// File: rtl/shift_register.sv
`default_nettype none
// ============================================================================
// Module   : shift_register
// Purpose  : MATRIX_SIZE independent rows, each OUTPUT_SIZE words deep, that
//            load in parallel and shift in lockstep; the head word of every
//            row is presented on data_out.
// Ports    : clock    - rising-edge clock, sole clock
//            reset    - synchronous active-high clear of all rows
//            load     - capture the whole data_in image (beats shift)
//            shift    - advance every row by one word
//            data_in  - [row][word] parallel load image
//            data_out - [row] head word of each row
// Config   : SHIFT_REGISTER_ROTATE_EN - when defined, rows rotate circularly
//            on shift instead of zero-filling the tail.
// Revision : 1.0 - initial release
// ============================================================================
module shift_register
  import shift_register_pkg::*;
#(
  parameter int DATA_BITS   = shift_register_pkg::DATA_BITS,
  parameter int MATRIX_SIZE = shift_register_pkg::MATRIX_SIZE,
  parameter int OUTPUT_SIZE = 2 * MATRIX_SIZE - 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] data_in  [0:MATRIX_SIZE-1][0:OUTPUT_SIZE-1],
  output logic [DATA_BITS-1:0] data_out [0:MATRIX_SIZE-1]
);

  // Every row shares the same load/shift/reset controls, so all rows move
  // together; there is deliberately no per-row enable.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_row
    shift_register_row #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (OUTPUT_SIZE)
    ) u_row (
      .clock   (clock),
      .reset   (reset),
      .load    (load),
      .shift   (shift),
      .data_in (data_in[i]),
      .head    (data_out[i])
    );
  end

endmodule : shift_register
`default_nettype wire

// File: tb/tb_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register
// Purpose  : Self-checking bench for shift_register. The stimulus process
//            applies one control pattern per clock edge and queues the
//            expected head-word vector; a separate monitor pops and compares
//            on the falling edge.
// Config   : honours SHIFT_REGISTER_ROTATE_EN for the expected overrun values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register;
  import shift_register_pkg::*;

  localparam int VW = DATA_BITS * MATRIX_SIZE;

  logic  clock = 1'b0;
  logic  reset = 1'b0;
  logic  load  = 1'b0;
  logic  shift = 1'b0;
  word_t data_in  [0:MATRIX_SIZE-1][0:OUTPUT_SIZE-1];
  word_t data_out [0:MATRIX_SIZE-1];

  logic [VW-1:0] exp_q  [$];
  string         name_q [$];

  int checks   = 0;
  int failures = 0;

  // Reference state: whether the rows hold the load pattern, and how many
  // shifts have happened since that load.
  bit loaded = 1'b0;
  int k      = 0;

  shift_register #(
    .DATA_BITS   (DATA_BITS),
    .MATRIX_SIZE (MATRIX_SIZE),
    .OUTPUT_SIZE (OUTPUT_SIZE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clock = ~clock;

  // Load pattern is data_in[i][j] = 15*i + j, so after kk shifts row i heads
  // with 15*i + kk until the row drains (or wraps when rotating).
  function automatic logic [VW-1:0] model(input bit ld, input int kk);
    logic [VW-1:0] v;
    int            val;
    v = '0;
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      val = 0;
      if (ld) begin
`ifdef SHIFT_REGISTER_ROTATE_EN
        val = OUTPUT_SIZE * i + (kk % OUTPUT_SIZE);
`else
        val = (kk < OUTPUT_SIZE) ? OUTPUT_SIZE * i + kk : 0;
`endif
      end
      v[i*DATA_BITS +: DATA_BITS] = DATA_BITS'(val);
    end
    return v;
  endfunction

  task automatic set_pattern();
    for (int i = 0; i < MATRIX_SIZE; i++)
      for (int j = 0; j < OUTPUT_SIZE; j++)
        data_in[i][j] = DATA_BITS'(OUTPUT_SIZE * i + j);
  endtask

  task automatic set_garbage();
    for (int i = 0; i < MATRIX_SIZE; i++)
      for (int j = 0; j < OUTPUT_SIZE; j++)
        data_in[i][j] = DATA_BITS'(8'hA5 ^ (i * 16 + j));
  endtask

  // Drive one edge worth of controls, then queue what the head words
  // must read after that edge.
  task automatic edge_op(input bit r, input bit l, input bit s, input string nm);
    reset = r;
    load  = l;
    shift = s;
    @(posedge clock);
    #1;
    if (r) begin
      loaded = 1'b0;
      k      = 0;
    end else if (l) begin
      loaded = 1'b1;
      k      = 0;
    end else if (s) begin
      k++;
    end
    exp_q.push_back(model(loaded, k));
    name_q.push_back(nm);
    reset = 1'b0;
    load  = 1'b0;
    shift = 1'b0;
  endtask

  // Monitor: compares whenever an expectation is outstanding.
  logic [VW-1:0] act_v;
  logic [VW-1:0] exp_v;
  string         cur_nm;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_v  = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      for (int i = 0; i < MATRIX_SIZE; i++)
        act_v[i*DATA_BITS +: DATA_BITS] = data_out[i];
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s: data_out(row7..row0)=%h expected %h", cur_nm, act_v, exp_v);
      end
    end
  end

  initial begin
    set_pattern();

    edge_op(1, 0, 0, "reset_1");
    edge_op(1, 0, 0, "reset_2");
    edge_op(0, 0, 0, "idle_after_reset");

    edge_op(0, 1, 0, "load");
    set_garbage();
    edge_op(0, 0, 0, "hold_1_data_in_changed");
    edge_op(0, 0, 0, "hold_2_data_in_changed");
    set_pattern();

    for (int n = 1; n <= OUTPUT_SIZE - 1; n++)
      edge_op(0, 0, 1, $sformatf("shift_%0d", n));
    edge_op(0, 0, 0, "hold_after_14_shifts");
    edge_op(0, 0, 1, "overrun_shift_15");
    edge_op(0, 0, 1, "overrun_shift_16");

    edge_op(0, 1, 1, "load_beats_shift");
    edge_op(0, 0, 1, "shift_after_prio_load");
    edge_op(1, 1, 0, "reset_beats_load");
    edge_op(1, 1, 1, "reset_beats_load_shift");

    edge_op(0, 1, 0, "reload");
    for (int n = 1; n <= 5; n++)
      edge_op(0, 0, 1, $sformatf("pre_reset_shift_%0d", n));
    edge_op(1, 0, 1, "reset_mid_shift");
    for (int n = 1; n <= 3; n++)
      edge_op(0, 0, 1, $sformatf("post_reset_shift_%0d", n));

    // Let the monitor drain the queue, bounded.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++)
      @(posedge clock);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_shift_register
`default_nettype wire
